// File: rtl/tachometer.sv
// Quadrature tachometer: filtered channel-A edge count per strobe window,
// scaled to RPM, with direction and stall status.
module tachometer #(
   parameter int RPM_RESOLUTION = 16,
   parameter int COUNT_WIDTH    = 16,
   parameter int FILTER_LEN     = 4,
   parameter int RPM_NUM        = 427,
   parameter int RPM_SHIFT      = 6,
   parameter int STALL_WINDOWS  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clk_en_tach,
   input  logic                      enc_a,
   input  logic                      enc_b,
   output logic [RPM_RESOLUTION-1:0] rpm_measured,
   output logic                      rpm_valid,
   output logic                      direction,
   output logic                      stalled
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int PW = COUNT_WIDTH + $clog2(RPM_NUM + 1);
   localparam int RW = (PW > RPM_RESOLUTION) ? PW : RPM_RESOLUTION + 1;
   localparam int SW = $clog2(STALL_WINDOWS + 1);

   logic [1:0]                sync_a;
   logic [1:0]                sync_b;
   logic                      filt_a;
   logic                      filt_b;
   logic                      filt_a_d;
   logic [FW-1:0]             fcnt_a;
   logic [FW-1:0]             fcnt_b;
   logic                      rise;
   logic [COUNT_WIDTH-1:0]    edge_cnt;
   logic [COUNT_WIDTH-1:0]    count_next;
   logic [COUNT_WIDTH-1:0]    count_latched;
   logic                      calc_pend;
   logic [PW-1:0]             product;
   logic [RW-1:0]             scaled;
   logic [RPM_RESOLUTION-1:0] rpm_next;
   logic [SW-1:0]             zero_cnt;
   logic [SW-1:0]             zero_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {sync_a[0], enc_a};
         sync_b <= {sync_b[0], enc_b};
      end
   end

   // A new level must hold FILTER_LEN cycles; any reversion restarts the run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_a <= 1'b0;
         filt_b <= 1'b0;
         fcnt_a <= '0;
         fcnt_b <= '0;
      end else begin
         if (sync_a[1] == filt_a) begin
            fcnt_a <= '0;
         end else if (fcnt_a == FW'(FILTER_LEN - 1)) begin
            filt_a <= sync_a[1];
            fcnt_a <= '0;
         end else begin
            fcnt_a <= fcnt_a + FW'(1);
         end
         if (sync_b[1] == filt_b) begin
            fcnt_b <= '0;
         end else if (fcnt_b == FW'(FILTER_LEN - 1)) begin
            filt_b <= sync_b[1];
            fcnt_b <= '0;
         end else begin
            fcnt_b <= fcnt_b + FW'(1);
         end
      end
   end

   assign rise = filt_a & ~filt_a_d;

   always_comb begin
      count_next = edge_cnt;
      if (rise && (edge_cnt != '1)) begin
         count_next = edge_cnt + COUNT_WIDTH'(1);
      end
   end

   // An edge in the strobe cycle belongs to the window being closed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_a_d      <= 1'b0;
         direction     <= 1'b1;
         edge_cnt      <= '0;
         count_latched <= '0;
         calc_pend     <= 1'b0;
      end else begin
         filt_a_d  <= filt_a;
         calc_pend <= clk_en_tach;
         if (rise) begin
            direction <= ~filt_b;
         end
         if (clk_en_tach) begin
            count_latched <= count_next;
            edge_cnt      <= '0;
         end else begin
            edge_cnt <= count_next;
         end
      end
   end

   always_comb begin
      product   = PW'(count_latched) * PW'(RPM_NUM);
      scaled    = RW'(product >> RPM_SHIFT);
      rpm_next  = scaled[RPM_RESOLUTION-1:0];
      if (scaled > RW'({RPM_RESOLUTION{1'b1}})) begin
         rpm_next = '1;
      end
      zero_next = '0;
      if (count_latched == '0) begin
         zero_next = (zero_cnt == SW'(STALL_WINDOWS)) ? zero_cnt
                                                      : zero_cnt + SW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rpm_measured <= '0;
         rpm_valid    <= 1'b0;
         stalled      <= 1'b0;
         zero_cnt     <= '0;
      end else begin
         rpm_valid <= calc_pend;
         if (calc_pend) begin
            rpm_measured <= rpm_next;
            zero_cnt     <= zero_next;
            stalled      <= (zero_next == SW'(STALL_WINDOWS));
         end
      end
   end

endmodule

// File: tb/tb_tachometer.sv
// Scoreboard bench for tachometer: expected speed/direction/stall pushed
// at each strobe, popped on rpm_valid.
module tb_tachometer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_en_tach = 1'b0;
   logic        enc_a = 1'b0;
   logic        enc_b = 1'b0;
   logic [15:0] rpm_measured;
   logic        rpm_valid;
   logic        direction;
   logic        stalled;

   logic        en2 = 1'b0;
   logic        enc_a2 = 1'b0;
   logic [5:0]  rpm_s, rpm_o;
   logic        val_s, val_o, dir_s, dir_o, stl_s, stl_o;

   typedef struct {
      int rpm;
      bit dir;
      bit stl;
   } exp_t;

   exp_t q[$];
   int   qs[$];
   int   qo[$];
   int   n_checks = 0;
   int   n_errors = 0;
   bit   dir_m = 1'b1;
   int   zc_m = 0;

   always #5 clk = ~clk;

   tachometer dut (
      .clk(clk), .reset(reset), .clk_en_tach(clk_en_tach),
      .enc_a(enc_a), .enc_b(enc_b),
      .rpm_measured(rpm_measured), .rpm_valid(rpm_valid),
      .direction(direction), .stalled(stalled)
   );

   // Small counter: saturation of the edge count itself.
   tachometer #(
      .RPM_RESOLUTION(6), .COUNT_WIDTH(4), .FILTER_LEN(1),
      .RPM_NUM(4), .RPM_SHIFT(0)
   ) dut_s (
      .clk(clk), .reset(reset), .clk_en_tach(en2),
      .enc_a(enc_a2), .enc_b(1'b0),
      .rpm_measured(rpm_s), .rpm_valid(val_s),
      .direction(dir_s), .stalled(stl_s)
   );

   // Narrow output: clipping of the scaled result.
   tachometer #(
      .RPM_RESOLUTION(6), .FILTER_LEN(1)
   ) dut_o (
      .clk(clk), .reset(reset), .clk_en_tach(en2),
      .enc_a(enc_a2), .enc_b(1'b0),
      .rpm_measured(rpm_o), .rpm_valid(val_o),
      .direction(dir_o), .stalled(stl_o)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void push_exp(input int cnt);
      exp_t e;
      int   r;
      r = (cnt * 427) >>> 6;
      if (cnt == 0) zc_m = (zc_m < 8) ? zc_m + 1 : 8;
      else zc_m = 0;
      e.rpm = (r > 65535) ? 65535 : r;
      e.dir = dir_m;
      e.stl = (zc_m >= 8);
      q.push_back(e);
   endfunction

   always @(posedge clk) begin
      #1;
      if (rpm_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rpm", int'(rpm_measured), e.rpm);
            chk("direction", int'(direction), int'(e.dir));
            chk("stalled", int'(stalled), int'(e.stl));
         end
      end
      if (val_s) begin
         if (qs.size() == 0) chk("unexpected_valid_s", 1, 0);
         else chk("rpm_count_sat", int'(rpm_s), qs.pop_front());
      end
      if (val_o) begin
         if (qo.size() == 0) chk("unexpected_valid_o", 1, 0);
         else chk("rpm_out_sat", int'(rpm_o), qo.pop_front());
      end
   end

   task automatic pulses(input int n, input bit b);
      enc_b = b;
      repeat (n) begin
         enc_a = 1'b1;
         repeat (5) @(negedge clk);
         enc_a = 1'b0;
         repeat (5) @(negedge clk);
      end
      if (n > 0) dir_m = ~b;
      repeat (10) @(negedge clk);
   endtask

   task automatic strobe(input int cnt);
      @(negedge clk);
      clk_en_tach = 1'b1;
      push_exp(cnt);
      @(negedge clk);
      clk_en_tach = 1'b0;
      @(posedge clk);
      #1 chk("valid_latency", int'(rpm_valid), 1);
      @(posedge clk);
      #1 chk("valid_one_cycle", int'(rpm_valid), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic pulses2(input int n);
      repeat (n) begin
         enc_a2 = 1'b1;
         repeat (2) @(negedge clk);
         enc_a2 = 1'b0;
         repeat (2) @(negedge clk);
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic strobe2(input int n);
      int r;
      @(negedge clk);
      en2 = 1'b1;
      qs.push_back(((n > 15) ? 15 : n) * 4);
      r = (n * 427) >>> 6;
      qo.push_back((r > 63) ? 63 : r);
      @(negedge clk);
      en2 = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rpm", int'(rpm_measured), 0);
      chk("reset_valid", int'(rpm_valid), 0);
      chk("reset_dir", int'(direction), 1);
      chk("reset_stalled", int'(stalled), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // nominal speed
      pulses(60, 1'b1);
      strobe(60);

      // edge coincident with strobe closes into this window
      pulses(9, 1'b0);
      @(negedge clk);
      enc_a = 1'b1;
      repeat (6) @(negedge clk);
      clk_en_tach = 1'b1;
      push_exp(10);
      @(negedge clk);
      clk_en_tach = 1'b0;
      repeat (10) @(negedge clk);
      enc_a = 1'b0;
      repeat (10) @(negedge clk);
      strobe(0);

      // glitches on A and B are rejected
      repeat (3) begin
         enc_a = 1'b1;
         repeat (3) @(negedge clk);
         enc_a = 1'b0;
         repeat (6) @(negedge clk);
      end
      enc_b = 1'b1;
      @(negedge clk);
      enc_b = 1'b0;
      repeat (8) @(negedge clk);
      strobe(0);
      enc_b = 1'b1;
      repeat (10) @(negedge clk);
      enc_a = 1'b1;
      repeat (4) @(negedge clk);
      enc_a = 1'b0;
      dir_m = 1'b0;
      repeat (12) @(negedge clk);
      strobe(1);

      // stall: 8 empty windows, the last two back to back
      repeat (6) strobe(0);
      @(negedge clk);
      clk_en_tach = 1'b1;
      push_exp(0);
      @(negedge clk);
      push_exp(0);
      @(negedge clk);
      clk_en_tach = 1'b0;
      repeat (6) @(negedge clk);
      pulses(5, 1'b1);
      strobe(5);

      // reset mid-window drops the partial count
      pulses(30, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_rpm", int'(rpm_measured), 0);
      chk("midrst_dir", int'(direction), 1);
      chk("midrst_stalled", int'(stalled), 0);
      @(posedge clk);
      #1 chk("midrst_valid", int'(rpm_valid), 0);
      @(negedge clk);
      reset = 1'b0;
      dir_m = 1'b1;
      zc_m = 0;
      repeat (3) @(negedge clk);
      pulses(12, 1'b1);
      strobe(12);

      // counter and output saturation on the narrow instances
      pulses2(20);
      strobe2(20);
      pulses2(10);
      strobe2(10);
      pulses2(9);
      strobe2(9);

      repeat (5) @(negedge clk);
      chk("drain_main", q.size(), 0);
      chk("drain_s", qs.size(), 0);
      chk("drain_o", qo.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tachometer.md
# tachometer

Measures wheel speed from one quadrature encoder channel pair and reports it as an unsigned RPM value, with direction and stall status. Sits between the motor encoder pins and the speed PID: the PID compares `rpm_measured` against the RPM setpoint from the motor controller and returns duty-cycle offsets. One instance per wheel. Measurement windows are delimited by the shared `clk_en_tach` strobe, so each new speed sample lines up with the motor controller's duty-cycle update.

## Interface

Parameters:
- `RPM_RESOLUTION`, default 16: width of `rpm_measured`.
- `COUNT_WIDTH`, default 16: width of the per-window edge counter.
- `FILTER_LEN`, default 4: number of consecutive stable cycles required before a filtered encoder input changes. Must be ≥ 1.
- `RPM_NUM`, default 427: RPM scale numerator. RPM = count·RPM_NUM >> RPM_SHIFT. Default fits 900 counts/rev and a 10 ms window.
- `RPM_SHIFT`, default 6: RPM scale right shift.
- `STALL_WINDOWS`, default 8: number of consecutive zero-count windows that declares a stall.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high.
- `clk_en_tach`, in, 1: one-cycle window-end strobe.
- `enc_a`, in, 1: encoder channel A, asynchronous.
- `enc_b`, in, 1: encoder channel B, asynchronous.
- `rpm_measured`, out, RPM_RESOLUTION: last computed speed.
- `rpm_valid`, out, 1: one-cycle pulse when `rpm_measured` updates.
- `direction`, out, 1: 1 = forward (B low at A rising edge).
- `stalled`, out, 1: high while the motor is considered stopped.

## Operation

- **Synchronizer.** `enc_a` and `enc_b` each pass through a 2-FF synchronizer.
- **Glitch filter.** Each channel has a filter counter. A synchronized value that differs from the filtered value must persist FILTER_LEN consecutive cycles before the filtered value takes it. Any reversion during that time restarts the count.
- **Edge detect.** Only rising edges of filtered A are counted. On each such edge, `direction` <= ~filtered B.
- **Edge counter.** Increments on each rising edge and saturates at 2^COUNT_WIDTH−1 (no wrap).
- **Window end** (cycle with `clk_en_tach`=1):
  - the counter value, plus that cycle's edge if present, is latched into `count_latched`;
  - the counter clears to 0;
  - an edge in the strobe cycle counts in the closing window, not the next one.
- **Compute stage.** One cycle after window end:
  - product = `count_latched`·RPM_NUM, full width COUNT_WIDTH+$clog2(RPM_NUM+1);
  - result = product >> RPM_SHIFT;
  - if result > 2^RPM_RESOLUTION−1, output all-ones; otherwise output the truncated result.
  - `rpm_measured` loads the value and `rpm_valid` pulses for one cycle.
- **Stall tracking.** A zero-count counter, saturating at STALL_WINDOWS, is updated at each window end:
  - zero-count window: increment the counter;
  - nonzero window: clear the counter and deassert `stalled`;
  - `stalled` asserts when the counter reaches STALL_WINDOWS.
  - `stalled` updates in the same cycle as `rpm_measured`.

## Timing

- Reset values: `rpm_measured`=0, `rpm_valid`=0, `direction`=1, `stalled`=0. Synchronizers, filters, counters and `count_latched` all reset to 0.
- Pin to edge-count latency: 2 sync cycles + FILTER_LEN filter cycles + 1 edge-detect cycle.
- `clk_en_tach` at cycle N → `rpm_valid` high at cycle N+1 only, with `rpm_measured` valid from N+1.
- Strobes on consecutive cycles are legal. Each produces its own `rpm_valid`, and a window with no edges yields 0.
- Reset mid-window discards the partial count. The first window after reset starts at reset deassertion.
- `rpm_measured`, `direction` and `stalled` hold between updates.

## Test plan

- **Nominal speed.** 60 clean A rising edges (B high) in a window, then strobe → one cycle later `rpm_valid`=1, `rpm_measured`=400, `direction`=0.
- **Coincident edge.** A filtered rising edge in the same cycle as `clk_en_tach`, with 9 prior edges → count 10, `rpm_measured`=66. The next window starts at 0.
- **Glitch rejection.** Pulses on A lasting 3 cycles (FILTER_LEN=4), plus a 1-cycle B glitch → zero counted edges, `direction` unchanged. A 4-cycle pulse counts once.
- **Stall.** 8 consecutive windows with no edges → `stalled` rises at the `rpm_valid` of the 8th window, `rpm_measured`=0. One window with 5 edges → `stalled`=0, `rpm_measured`=33.
- **Saturation.** Edge counter forced to 65535 edges in a window → count held at 65535 (no wrap), `rpm_measured`=65535.
- **Reset mid-window.** 30 edges, then assert `reset` for 2 cycles, then 12 edges and a strobe → all outputs at reset values during reset, then `rpm_measured`=80.
